rf_dump_reader: RTL and testbench

- Sequential read-out engine for the integer register file.
- On command, walks a programmable address range over one register-file read port.
- Emits each (address, data) pair on a valid/ready stream toward the debug/trace path.
- Frees software and the debug unit from cycle-by-cycle port control when snapshotting architectural state.

---
 rtl/rf_dump_reader_pkg.sv | 15 +
 rtl/rf_dump_reader.sv | 130 +++++++++++++
 tb/tb_rf_dump_reader.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rf_dump_reader_pkg.sv
// Shared definitions for the register-file dump reader: state encoding and
// the data/address widths it shares with the integer register file.
package rf_dump_reader_pkg;

  localparam int RF_WIDTH      = 32;
  localparam int RF_DEPTH_BITS = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_SEND = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/rf_dump_reader.sv
// Walks an inclusive, wrapping address range over one register-file read port
// and streams each (address, data) snapshot on a valid/ready interface.
module rf_dump_reader
  import rf_dump_reader_pkg::*;
#(
  parameter int WIDTH      = RF_WIDTH,
  parameter int DEPTH_BITS = RF_DEPTH_BITS
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  Start,
  input  logic                  Abort,
  input  logic [DEPTH_BITS-1:0] FirstAddr,
  input  logic [DEPTH_BITS-1:0] LastAddr,
  output logic [DEPTH_BITS-1:0] RfRdAddress,
  input  logic [WIDTH-1:0]      RfRdData,
  output logic [WIDTH-1:0]      OutData,
  output logic [DEPTH_BITS-1:0] OutAddr,
  output logic                  OutValid,
  input  logic                  OutReady,
  output logic                  Busy,
  output logic                  Done
);

  state_t                  state_r, state_s;
  logic [DEPTH_BITS-1:0]   addr_r, addr_s;
  logic [DEPTH_BITS-1:0]   last_r, last_s;
  logic [DEPTH_BITS-1:0]   out_addr_r, out_addr_s;
  logic [WIDTH-1:0]        out_data_r, out_data_s;
  logic                    out_valid_r, out_valid_s;
  logic                    busy_r, busy_s;
  logic                    done_r, done_s;
  logic                    handshake_s;
  logic                    at_last_s;

  assign handshake_s = out_valid_r & OutReady;
  assign at_last_s   = (addr_r == last_r);

  // Next-state and next-output decode; Abort takes priority in every active state.
  always_comb begin
    state_s     = state_r;
    addr_s      = addr_r;
    last_s      = last_r;
    out_addr_s  = out_addr_r;
    out_data_s  = out_data_r;
    out_valid_s = out_valid_r;
    done_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        out_valid_s = 1'b0;
        if (Start && !Abort) begin
          addr_s  = FirstAddr;
          last_s  = LastAddr;
          state_s = ST_READ;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_READ: begin
        if (Abort) begin
          out_valid_s = 1'b0;
          state_s     = ST_IDLE;
        end else begin
          // RfRdData reflects pre-edge contents, so this is the snapshot point.
          out_data_s  = RfRdData;
          out_addr_s  = addr_r;
          out_valid_s = 1'b1;
          state_s     = ST_SEND;
        end
      end
      ST_SEND: begin
        if (Abort) begin
          out_valid_s = 1'b0;
          state_s     = ST_IDLE;
        end else if (handshake_s) begin
          out_valid_s = 1'b0;
          if (at_last_s) begin
            done_s  = 1'b1;
            state_s = ST_DONE;
          end else begin
            addr_s  = addr_r + DEPTH_BITS'(1);
            state_s = ST_READ;
          end
        end else begin
          state_s = ST_SEND;
        end
      end
      ST_DONE: begin
        out_valid_s = 1'b0;
        state_s     = ST_IDLE;
      end
      default: begin
        out_valid_s = 1'b0;
        state_s     = ST_IDLE;
      end
    endcase
    busy_s = (state_s != ST_IDLE);
  end

  // State and output registers; Done is registered so it is high exactly while in DONE.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r     <= ST_IDLE;
      addr_r      <= '0;
      last_r      <= '0;
      out_addr_r  <= '0;
      out_data_r  <= '0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      addr_r      <= addr_s;
      last_r      <= last_s;
      out_addr_r  <= out_addr_s;
      out_data_r  <= out_data_s;
      out_valid_r <= out_valid_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
    end
  end

  assign RfRdAddress = addr_r;
  assign OutData     = out_data_r;
  assign OutAddr     = out_addr_r;
  assign OutValid    = out_valid_r;
  assign Busy        = busy_r;
  assign Done        = done_r;

endmodule

// File: tb/tb_rf_dump_reader.sv
// Self-checking bench for rf_dump_reader: a bench-side register file, a
// handshake monitor and a range/wrap reference model of the expected stream.
module tb_rf_dump_reader;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        Start = 1'b0;
  logic        Abort = 1'b0;
  logic        OutReady = 1'b0;
  logic [4:0]  FirstAddr = 5'd0;
  logic [4:0]  LastAddr = 5'd0;
  logic [4:0]  RfRdAddress, OutAddr;
  logic [31:0] RfRdData, OutData;
  logic        OutValid, Busy, Done;

  logic [31:0] rf [32];
  logic [31:0] load_img [32];
  logic        load_en = 1'b0;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = 5'd0;
  logic [31:0] wr_data = 32'd0;

  int n_cmp = 0;
  int n_err = 0;

  logic [4:0]  got_addr [$];
  logic [31:0] got_data [$];
  int   done_pulses, done_cyc, first_hs, last_hs, first_valid, abort_cyc, end_cyc, unstable_cnt;
  logic end_valid;
  bit   timed_out;

  rf_dump_reader dut (
    .CLK(CLK), .RST(RST), .Start(Start), .Abort(Abort),
    .FirstAddr(FirstAddr), .LastAddr(LastAddr),
    .RfRdAddress(RfRdAddress), .RfRdData(RfRdData),
    .OutData(OutData), .OutAddr(OutAddr), .OutValid(OutValid), .OutReady(OutReady),
    .Busy(Busy), .Done(Done)
  );

  always #5 CLK = ~CLK;

  // Register file: combinational read, write visible only after the edge.
  assign RfRdData = rf[RfRdAddress];
  always @(posedge CLK) begin
    if (load_en) rf <= load_img;
    else if (wr_en) rf[wr_addr] <= wr_data;
  end

  task automatic load_rf(input bit ramp);
    for (int i = 0; i < 32; i++) load_img[i] = ramp ? 32'(3 * i) : $urandom;
    load_en = 1'b1;
    @(negedge CLK);
    load_en = 1'b0;
  endtask

  task automatic start_dump(input logic [4:0] f, input logic [4:0] l);
    FirstAddr = f;
    LastAddr  = l;
    Start     = 1'b1;
    @(negedge CLK);
    Start     = 1'b0;
  endtask

  // Consumer/monitor: stall<0 means random ready, otherwise 'stall' low cycles per word.
  task automatic collect(input int stall, input int abort_word, input int restart_at, input int budget);
    int stall_ctr;
    bit prev_wait;
    logic [4:0]  prev_a;
    logic [31:0] prev_d;
    got_addr.delete(); got_data.delete();
    done_pulses = 0; done_cyc = -1; first_hs = -1; last_hs = -1; first_valid = -1;
    abort_cyc = -1; end_cyc = -1; unstable_cnt = 0; timed_out = 1'b1; end_valid = 1'b0;
    stall_ctr = 0; prev_wait = 1'b0; prev_a = 5'd0; prev_d = 32'd0;
    for (int cyc = 0; cyc < budget; cyc++) begin
      Abort = 1'b0;
      Start = 1'b0;
      if (prev_wait && OutValid && ({OutAddr, OutData} !== {prev_a, prev_d})) unstable_cnt++;
      if (Done === 1'b1) begin done_pulses++; done_cyc = cyc; end
      if (OutValid === 1'b1 && first_valid < 0) first_valid = cyc;
      if (Busy === 1'b0) begin
        timed_out = 1'b0; end_cyc = cyc; end_valid = OutValid;
        break;
      end
      if (cyc == restart_at) begin Start = 1'b1; FirstAddr = 5'd0; LastAddr = 5'd31; end
      if (!OutValid || stall < 0) OutReady = 1'($urandom_range(0, 1));
      else if (stall_ctr < stall) begin OutReady = 1'b0; stall_ctr++; end
      else OutReady = 1'b1;
      if (abort_word >= 0 && OutValid && got_addr.size() == abort_word) begin
        Abort = 1'b1; OutReady = 1'b0; abort_cyc = cyc;
      end
      if (OutValid && OutReady) begin
        got_addr.push_back(OutAddr);
        got_data.push_back(OutData);
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
        stall_ctr = 0;
      end
      prev_wait = OutValid && !OutReady;
      prev_a = OutAddr;
      prev_d = OutData;
      @(negedge CLK);
    end
    Abort = 1'b0;
    Start = 1'b0;
  endtask

  task automatic test_reset();
    #1 RST = 1'b0;
    repeat (2) @(negedge CLK);
    n_cmp++;
    if ({OutValid, Busy, Done, RfRdAddress, OutAddr, OutData} !== 40'd0) begin
      n_err++;
      $display("FAIL reset_state: got v=%b b=%b d=%b rda=%0d oa=%0d od=%0h expected all zero",
               OutValid, Busy, Done, RfRdAddress, OutAddr, OutData);
    end
    RST = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_full_dump();
    load_rf(1'b1);
    OutReady = 1'b1;
    start_dump(5'd0, 5'd31);
    n_cmp++;
    if ({OutValid, Busy} !== 2'b01) begin
      n_err++; $display("FAIL full_after_start: got valid=%b busy=%b expected valid=0 busy=1", OutValid, Busy);
    end
    collect(0, -1, -1, 400);
    n_cmp++;
    if (timed_out) begin n_err++; $display("FAIL full_timeout: got timeout expected completion"); end
    n_cmp++;
    if (first_valid != 1) begin n_err++; $display("FAIL full_latency: got %0d expected 1", first_valid); end
    n_cmp++;
    if (got_addr.size() != 32) begin n_err++; $display("FAIL full_count: got %0d expected 32", got_addr.size()); end
    for (int i = 0; i < 32 && i < got_addr.size(); i++) begin
      n_cmp++;
      if ({got_addr[i], got_data[i]} !== {5'(i), 32'(3 * i)}) begin
        n_err++; $display("FAIL full_word%0d: got %0d/%0h expected %0d/%0h", i, got_addr[i], got_data[i], i, 3 * i);
      end
    end
    n_cmp++;
    if (last_hs - first_hs != 62) begin n_err++; $display("FAIL full_throughput: got span %0d expected 62", last_hs - first_hs); end
    n_cmp++;
    if (done_pulses != 1 || done_cyc != last_hs + 1) begin
      n_err++; $display("FAIL full_done: got pulses=%0d at %0d expected 1 at %0d", done_pulses, done_cyc, last_hs + 1);
    end
    n_cmp++;
    if (end_cyc != last_hs + 2) begin n_err++; $display("FAIL full_busy_drop: got %0d expected %0d", end_cyc, last_hs + 2); end
  endtask

  task automatic test_backpressure();
    load_rf(1'b0);
    start_dump(5'd4, 5'd6);
    collect(5, -1, -1, 200);
    n_cmp++;
    if (got_addr.size() != 3) begin n_err++; $display("FAIL bp_count: got %0d expected 3", got_addr.size()); end
    for (int i = 0; i < 3 && i < got_addr.size(); i++) begin
      n_cmp++;
      if ({got_addr[i], got_data[i]} !== {5'(4 + i), load_img[4 + i]}) begin
        n_err++; $display("FAIL bp_word%0d: got %0d/%0h expected %0d/%0h", i, got_addr[i], got_data[i], 4 + i, load_img[4 + i]);
      end
    end
    n_cmp++;
    if (unstable_cnt != 0) begin n_err++; $display("FAIL bp_stable: got %0d changes expected 0", unstable_cnt); end
    n_cmp++;
    if (last_hs - first_hs != 14) begin n_err++; $display("FAIL bp_spacing: got %0d expected 14", last_hs - first_hs); end
    n_cmp++;
    if (done_pulses != 1) begin n_err++; $display("FAIL bp_done: got %0d expected 1", done_pulses); end
  endtask

  task automatic test_wrap();
    logic [4:0] exp_a;
    load_rf(1'b0);
    start_dump(5'd30, 5'd1);
    collect(-1, -1, -1, 300);
    n_cmp++;
    if (got_addr.size() != 4) begin n_err++; $display("FAIL wrap_count: got %0d expected 4", got_addr.size()); end
    for (int i = 0; i < 4 && i < got_addr.size(); i++) begin
      exp_a = 5'((30 + i) % 32);
      n_cmp++;
      if ({got_addr[i], got_data[i]} !== {exp_a, load_img[exp_a]}) begin
        n_err++; $display("FAIL wrap_word%0d: got %0d/%0h expected %0d/%0h", i, got_addr[i], got_data[i], exp_a, load_img[exp_a]);
      end
    end
    n_cmp++;
    if (done_pulses != 1 || timed_out) begin n_err++; $display("FAIL wrap_done: got %0d expected 1", done_pulses); end
  endtask

  task automatic test_single_ignored_start();
    load_rf(1'b0);
    start_dump(5'd5, 5'd5);
    collect(3, -1, 1, 200);
    n_cmp++;
    if (got_addr.size() != 1) begin n_err++; $display("FAIL single_count: got %0d expected 1", got_addr.size()); end
    if (got_addr.size() > 0) begin
      n_cmp++;
      if ({got_addr[0], got_data[0]} !== {5'd5, load_img[5]}) begin
        n_err++; $display("FAIL single_word: got %0d/%0h expected 5/%0h", got_addr[0], got_data[0], load_img[5]);
      end
    end
    repeat (3) @(negedge CLK);
    n_cmp++;
    if ({Busy, OutValid} !== 2'b00) begin n_err++; $display("FAIL single_no_restart: got busy=%b valid=%b expected 0 0", Busy, OutValid); end
  endtask

  task automatic test_abort();
    load_rf(1'b0);
    start_dump(5'd0, 5'd7);
    collect(0, 2, -1, 200);
    n_cmp++;
    if (got_addr.size() != 2) begin n_err++; $display("FAIL abort_count: got %0d expected 2", got_addr.size()); end
    n_cmp++;
    if (end_cyc != abort_cyc + 1 || end_valid !== 1'b0 || timed_out) begin
      n_err++; $display("FAIL abort_stop: got end=%0d valid=%b expected end=%0d valid=0", end_cyc, end_valid, abort_cyc + 1);
    end
    n_cmp++;
    if (done_pulses != 0) begin n_err++; $display("FAIL abort_no_done: got %0d expected 0", done_pulses); end
    Start = 1'b1; Abort = 1'b1; FirstAddr = 5'd2; LastAddr = 5'd3;
    @(negedge CLK);
    Start = 1'b0; Abort = 1'b0;
    @(negedge CLK);
    n_cmp++;
    if ({Busy, OutValid} !== 2'b00) begin n_err++; $display("FAIL abort_start_idle: got busy=%b valid=%b expected 0 0", Busy, OutValid); end
  endtask

  task automatic test_snapshot();
    logic [4:0]  x;
    logic [31:0] old_v;
    load_rf(1'b0);
    x = 5'($urandom_range(0, 31));
    old_v = load_img[x];
    OutReady = 1'b0;
    start_dump(x, x);
    wr_en = 1'b1; wr_addr = x; wr_data = ~old_v;
    @(negedge CLK);
    wr_data = old_v ^ 32'h5a5a_a5a5;
    @(negedge CLK);
    wr_en = 1'b0;
    n_cmp++;
    if ({OutValid, OutAddr, OutData} !== {1'b1, x, old_v}) begin
      n_err++; $display("FAIL snapshot_held: got v=%b %0d/%0h expected 1 %0d/%0h", OutValid, OutAddr, OutData, x, old_v);
    end
    collect(0, -1, -1, 50);
    n_cmp++;
    if (got_data.size() != 1 || got_data[0] !== old_v) begin
      n_err++; $display("FAIL snapshot_streamed: got %0d words expected 1 word %0h", got_data.size(), old_v);
    end
  endtask

  task automatic test_reset_mid_dump();
    logic [4:0] exp_a;
    load_rf(1'b0);
    OutReady = 1'b0;
    start_dump(5'd3, 5'd9);
    @(negedge CLK);
    n_cmp++;
    if ({OutValid, RfRdAddress} !== {1'b1, 5'd3}) begin
      n_err++; $display("FAIL rstmid_pre: got v=%b rda=%0d expected 1 3", OutValid, RfRdAddress);
    end
    #2 RST = 1'b0;
    #1;
    n_cmp++;
    if ({OutValid, Busy, Done, RfRdAddress} !== 8'd0) begin
      n_err++; $display("FAIL rstmid_async: got v=%b b=%b d=%b rda=%0d expected 0", OutValid, Busy, Done, RfRdAddress);
    end
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    start_dump(5'd10, 5'd12);
    collect(-1, -1, -1, 200);
    n_cmp++;
    if (got_addr.size() != 3 || done_pulses != 1) begin
      n_err++; $display("FAIL rstmid_restart: got %0d words %0d done expected 3 1", got_addr.size(), done_pulses);
    end
    for (int i = 0; i < 3 && i < got_addr.size(); i++) begin
      exp_a = 5'(10 + i);
      n_cmp++;
      if ({got_addr[i], got_data[i]} !== {exp_a, load_img[exp_a]}) begin
        n_err++; $display("FAIL rstmid_word%0d: got %0d/%0h expected %0d/%0h", i, got_addr[i], got_data[i], exp_a, load_img[exp_a]);
      end
    end
  endtask

  task automatic test_random();
    logic [4:0] f, l, exp_a;
    int n, bad;
    for (int t = 0; t < 8; t++) begin
      load_rf(1'b0);
      f = 5'($urandom_range(0, 31));
      l = 5'($urandom_range(0, 31));
      n = ((int'(l) - int'(f) + 32) % 32) + 1;
      start_dump(f, l);
      collect(-1, -1, -1, 3000);
      n_cmp++;
      if (got_addr.size() != n || done_pulses != 1 || timed_out) begin
        n_err++; $display("FAIL rand%0d_count: got %0d words %0d done expected %0d 1 (f=%0d l=%0d)",
                          t, got_addr.size(), done_pulses, n, f, l);
      end
      bad = 0;
      for (int i = 0; i < n && i < got_addr.size(); i++) begin
        exp_a = 5'((int'(f) + i) % 32);
        if ({got_addr[i], got_data[i]} !== {exp_a, load_img[exp_a]}) bad++;
      end
      n_cmp++;
      if (bad != 0 || unstable_cnt != 0) begin
        n_err++; $display("FAIL rand%0d_words: got %0d wrong %0d unstable expected 0 0", t, bad, unstable_cnt);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_full_dump();
    test_backpressure();
    test_wrap();
    test_single_ignored_start();
    test_abort();
    test_snapshot();
    test_reset_mid_dump();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
